multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Issue/response controller in front of the slow iterative multiply/divide datapath (operator_i, signed_mode_i, mult_en_i/div_en_i, ready_o interface).
- Accepts a decoded RV32M request via valid/ready, registers the operands, and holds the datapath enable until completion.
- Captures the one-cycle-valid result and returns it on a valid/ready response port.
- Owns arbitration of the shared ALU adder between the main ALU and the multdiv datapath, and drains the datapath safely on pipeline flush.

Parameters:
TIMEOUT_CYC, 64, max cycles in RUN/DRAIN before err_o is set; must be > 40.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous assert, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a_i  in  32  rs1 operand
req_b_i  in  32  rs2 operand
flush_i  in  1  kill the in-flight or pending instruction
md_mult_en_o  out  1  datapath multiply enable
md_div_en_o  out  1  datapath divide enable
md_operator_o  out  2  MD_OP_MULL/MULH/DIV/REM
md_signed_mode_o  out  2  [0] a signed, [1] b signed
md_op_a_o  out  32  registered operand a
md_op_b_o  out  32  registered operand b
md_equal_to_zero_o  out  1  registered (op_b == 0)
md_ready_i  in  1  datapath done; result valid this cycle only
md_result_i  in  32  datapath result
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  result consumed
rsp_data_o  out  32  result
alu_req_i  in  1  main ALU requests the adder
alu_gnt_o  out  1  main ALU owns the adder this cycle
adder_sel_o  out  1  1 = adder operands from multdiv
busy_o  out  1  state != IDLE
err_o  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state IDLE; operand, result and timer registers 0.
- States: IDLE, RUN, RESP, DRAIN.
- IDLE:
  - req_ready_o = !flush_i.
  - On accept, register op/a/b and go to RUN.
  - Enables are registered, so they rise the cycle after accept.
- Op decode, registered at accept:
  - MUL: MULL, mode 11.
  - MULH: MULH, 11. MULHSU: MULH, 01. MULHU: MULH, 00.
  - DIV: DIV, 11. DIVU: DIV, 00. REM: REM, 11. REMU: REM, 00.
  - md_mult_en_o is set for MUL* ops; md_div_en_o for DIV/REM ops. Exactly one is high in RUN/DRAIN, never both.
- RUN:
  - Enable held high; operands held stable.
  - On md_ready_i: capture md_result_i into rsp_data_o, go to RESP, drop the enable the next cycle. The datapath must not see the enable in the cycle after ready_o, otherwise it restarts.
  - flush_i without md_ready_i: go to DRAIN.
  - flush_i with md_ready_i: go to IDLE, no response.
- DRAIN:
  - Enable held until md_ready_i, because the datapath cannot be aborted mid-sequence. The result is discarded, then go to IDLE.
  - flush_i is ignored.
- RESP:
  - rsp_valid_o = 1; data stable until rsp_valid&rsp_ready.
  - On handshake go to IDLE; a new request is accepted no earlier than the next cycle.
  - flush_i: drop the response, go to IDLE. flush_i wins over rsp_ready_i in the same cycle.
- Adder arbitration:
  - adder_sel_o = 1 in RUN and DRAIN. alu_gnt_o = alu_req_i & !adder_sel_o.
  - In the accept cycle the ALU may still hold the adder.
- Timer:
  - Cleared on entry to RUN and counts in RUN/DRAIN.
  - At TIMEOUT_CYC: set err_o (sticky until rst), force IDLE, drop enables.
- Reset mid-operation returns to IDLE immediately and clears err_o.
- busy_o = (state != IDLE).

Decomposition:
- Shared package holds:
  - md_op_e for the 2-bit datapath operator (MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3).
  - The 3-bit RV32M funct3 request encoding.
  - The ctrl state enum.
- One natural sub-module: md_op_decode (combinational funct3 -> operator, signed_mode, mult/div select).
- Arbitration and timer stay inline.

Test Plan:
- MUL a=7, b=-3 with the real slow datapath attached -> rsp_data=0xFFFFFFEB; mult_en high from accept+1 until the ready cycle, low the cycle after; exactly one response.
- DIV a=-20, b=3 -> 0xFFFFFFFA; then REM same operands -> 0xFFFFFFFE; DIVU a=x, b=0 -> md_equal_to_zero_o=1, fast completion, rsp_data=0xFFFFFFFF.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF; check md_signed_mode_o 00 and 01 respectively.
- flush_i 5 cycles after accepting DIV -> DRAIN; div_en held until md_ready; no rsp_valid; req_ready_o returns 1 in IDLE; the next MUL 3*4 returns 12.
- rsp_ready_i held 0 for 10 cycles in RESP -> rsp_valid/rsp_data stable, req_ready_o=0; alu_req_i=1 throughout RUN -> alu_gnt_o=0 and adder_sel_o=1 throughout RUN, alu_gnt_o=1 in IDLE and RESP.
- Stub datapath never asserting md_ready_i with TIMEOUT_CYC=64 -> err_o set 64 cycles after RUN entry, enables low, state IDLE; rst pulse clears err_o.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types for the multiply/divide issue controller.
//   md_op_e      : 2-bit operator seen by the iterative datapath
//   rv32m_op_e   : 3-bit RV32M funct3 request encoding
//   ctrl_state_e : issue controller state
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } rv32m_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/multdiv_issue_ctrl_md_op_decode.sv
// Combinational RV32M funct3 decode into datapath controls.
//   op          : RV32M request op
//   operator    : datapath operator
//   signed_mode : [0] operand a signed, [1] operand b signed
//   mult_sel    : op uses the multiplier
//   div_sel     : op uses the divider
module md_op_decode
    import multdiv_issue_ctrl_pkg::*;
(
    input  rv32m_op_e  op,
    output md_op_e     operator,
    output logic [1:0] signed_mode,
    output logic       mult_sel,
    output logic       div_sel
);

    always_comb begin
        operator    = MD_OP_MULL;
        signed_mode = 2'b00;
        case (op)
            OP_MUL:    begin operator = MD_OP_MULL; signed_mode = 2'b11; end
            OP_MULH:   begin operator = MD_OP_MULH; signed_mode = 2'b11; end
            OP_MULHSU: begin operator = MD_OP_MULH; signed_mode = 2'b01; end
            OP_MULHU:  begin operator = MD_OP_MULH; signed_mode = 2'b00; end
            OP_DIV:    begin operator = MD_OP_DIV;  signed_mode = 2'b11; end
            OP_DIVU:   begin operator = MD_OP_DIV;  signed_mode = 2'b00; end
            OP_REM:    begin operator = MD_OP_REM;  signed_mode = 2'b11; end
            OP_REMU:   begin operator = MD_OP_REM;  signed_mode = 2'b00; end
            default:   begin operator = MD_OP_MULL; signed_mode = 2'b00; end
        endcase
    end

    // funct3[2] splits multiply ops from divide/remainder ops
    assign mult_sel = ~op[2];
    assign div_sel  =  op[2];

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/response controller in front of the iterative multiply/divide datapath.
//   req_*      : valid/ready request port (op, rs1, rs2), flush_i kills the op
//   md_*       : datapath enables, operator, signed mode, registered operands;
//                md_ready_i/md_result_i is the one-cycle completion strobe
//   rsp_*      : valid/ready result port
//   alu_req_i/alu_gnt_o/adder_sel_o : shared adder arbitration
//   busy_o     : controller not idle; err_o : sticky completion timeout
// TIMEOUT_CYC must exceed the longest datapath sequence (> 40 cycles).
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_equal_to_zero_o,
    input  logic        md_ready_i,
    input  logic [31:0] md_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    input  logic        alu_req_i,
    output logic        alu_gnt_o,
    output logic        adder_sel_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ctrl_state_e   state, state_nxt;
    md_op_e        dec_operator, operator_q;
    logic [1:0]    dec_mode, mode_q;
    logic          dec_mult, dec_div, mult_q, div_q;
    logic [31:0]   op_a_q, op_b_q, result_q;
    logic          eq_zero_q, err_q;
    logic [TW-1:0] timer_q;
    logic          running, accept, timeout, capture;

    md_op_decode u_decode (
        .op          (rv32m_op_e'(req_op_i)),
        .operator    (dec_operator),
        .signed_mode (dec_mode),
        .mult_sel    (dec_mult),
        .div_sel     (dec_div)
    );

    assign running = (state == ST_RUN) || (state == ST_DRAIN);
    assign accept  = (state == ST_IDLE) && req_valid_i && !flush_i;
    // Completion in the last allowed cycle still counts as completion.
    assign timeout = running && !md_ready_i && (timer_q == TW'(TIMEOUT_CYC - 1));
    assign capture = (state == ST_RUN) && md_ready_i && !flush_i;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (md_ready_i)   state_nxt = flush_i ? ST_IDLE : ST_RESP;
                else if (timeout) state_nxt = ST_IDLE;
                else if (flush_i) state_nxt = ST_DRAIN;
            end
            // datapath cannot be aborted: wait for its done strobe, ignore flush
            ST_DRAIN: if (md_ready_i || timeout) state_nxt = ST_IDLE;
            ST_RESP:  if (flush_i || rsp_ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            operator_q <= MD_OP_MULL;
            mode_q     <= 2'b00;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            eq_zero_q  <= 1'b0;
            result_q   <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                operator_q <= dec_operator;
                mode_q     <= dec_mode;
                mult_q     <= dec_mult;
                div_q      <= dec_div;
                op_a_q     <= req_a_i;
                op_b_q     <= req_b_i;
                eq_zero_q  <= (req_b_i == 32'd0);
                timer_q    <= '0;
            end else if (running) begin
                timer_q <= timer_q + 1'b1;
            end
            if (capture) result_q <= md_result_i;
            if (timeout) err_q    <= 1'b1;
        end
    end

    // Enables follow the registered state, so they rise the cycle after
    // accept and fall on the same edge that leaves RUN/DRAIN; the datapath
    // never sees the enable in the cycle after its done strobe.
    assign md_mult_en_o       = running && mult_q;
    assign md_div_en_o        = running && div_q;
    assign md_operator_o      = operator_q;
    assign md_signed_mode_o   = mode_q;
    assign md_op_a_o          = op_a_q;
    assign md_op_b_o          = op_b_q;
    assign md_equal_to_zero_o = eq_zero_q;

    // Combinational outputs are gated by rst so every output reads 0 in reset.
    assign req_ready_o = !rst && (state == ST_IDLE) && !flush_i;
    assign rsp_valid_o = (state == ST_RESP);
    assign rsp_data_o  = result_q;
    assign adder_sel_o = running;
    assign alu_gnt_o   = !rst && alu_req_i && !running;
    assign busy_o      = (state != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with a behavioural slow datapath.
module tb_multdiv_issue_ctrl;
    import multdiv_issue_ctrl_pkg::*;

    localparam int LAT_MUL = 34;
    localparam int LAT_DIV = 36;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = 3'd0;
    logic [31:0] req_a_i = '0;
    logic [31:0] req_b_i = '0;
    logic        flush_i = 1'b0;
    logic        md_mult_en_o, md_div_en_o;
    logic [1:0]  md_operator_o, md_signed_mode_o;
    logic [31:0] md_op_a_o, md_op_b_o;
    logic        md_equal_to_zero_o;
    logic        md_ready_i;
    logic [31:0] md_result_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        alu_req_i = 1'b0;
    logic        alu_gnt_o, adder_sel_o, busy_o, err_o;

    int errors = 0;
    int checks = 0;
    bit dp_hang = 1'b0;

    multdiv_issue_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .flush_i(flush_i),
        .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
        .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
        .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
        .md_equal_to_zero_o(md_equal_to_zero_o),
        .md_ready_i(md_ready_i), .md_result_i(md_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .alu_req_i(alu_req_i), .alu_gnt_o(alu_gnt_o), .adder_sel_o(adder_sel_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ---------------- slow datapath model ----------------
    function automatic logic [31:0] dp_calc(input logic [1:0] opr, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        case (opr)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: if (b == 32'd0) return 32'hFFFF_FFFF;
                  else if (sm == 2'b11) return $signed(a) / $signed(b);
                  else return a / b;
            default: if (b == 32'd0) return a;
                  else if (sm == 2'b11) return $signed(a) % $signed(b);
                  else return a % b;
        endcase
    endfunction

    logic dp_busy;
    int   dp_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_busy     <= 1'b0;
            dp_cnt      <= 0;
            md_ready_i  <= 1'b0;
            md_result_i <= '0;
        end else begin
            md_ready_i <= 1'b0;
            if (!dp_busy) begin
                // an enable seen right after the done strobe would restart it
                if ((md_mult_en_o || md_div_en_o) && !md_ready_i && !dp_hang) begin
                    dp_busy <= 1'b1;
                    dp_cnt  <= (md_div_en_o && md_equal_to_zero_o) ? 1 :
                               (md_mult_en_o ? LAT_MUL : LAT_DIV);
                end
            end else if (dp_cnt == 0) begin
                md_ready_i  <= 1'b1;
                md_result_i <= dp_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
                dp_busy     <= 1'b0;
            end else begin
                dp_cnt <= dp_cnt - 1;
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    // Returns at the negedge following the accepting clock edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b;
        for (int i = 0; i < 50 && !req_ready_o; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Waits for rsp_valid_o; leaves the response pending.
    task automatic wait_rsp(output logic [31:0] data, output int cyc, output bit to);
        to = 1'b1; cyc = 0; data = '0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid_o) begin to = 1'b0; cyc = i; break; end
            @(negedge clk);
        end
        data = rsp_data_o;
    endtask

    task automatic take_rsp();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++; if ({md_mult_en_o, md_div_en_o, rsp_valid_o, adder_sel_o, alu_gnt_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 00000", {md_mult_en_o, md_div_en_o, rsp_valid_o, adder_sel_o, alu_gnt_o}); end
        checks++; if ({rsp_data_o, md_op_a_o, md_op_b_o} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {rsp_data_o, md_op_a_o, md_op_b_o}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready_o); end
    endtask

    task automatic test_mul();
        int drops = 0; int pulses = 0; bit seen = 1'b0;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        checks++; if (md_mult_en_o !== 1'b1 || md_div_en_o !== 1'b0) begin
            errors++; $display("FAIL mul_en_rise got mult=%b div=%b exp 1/0", md_mult_en_o, md_div_en_o); end
        checks++; if ({md_operator_o, md_signed_mode_o} !== 4'b0011) begin
            errors++; $display("FAIL mul_decode got %b exp 0011", {md_operator_o, md_signed_mode_o}); end
        for (int i = 0; i < 200; i++) begin
            if (!md_mult_en_o) drops++;
            if (md_ready_i) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen || drops != 0) begin errors++; $display("FAIL mul_en_held got ready=%b drops=%0d exp 1/0", seen, drops); end
        @(negedge clk);
        checks++; if (md_mult_en_o !== 1'b0) begin errors++; $display("FAIL mul_en_fall got %b exp 0", md_mult_en_o); end
        checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mul_rsp got v=%b d=%h exp 1/ffffffeb", rsp_valid_o, rsp_data_o); end
        take_rsp();
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mul_one_rsp got %0d extra cycles valid exp 0", pulses); end
    endtask

    task automatic test_div_rem();
        logic [31:0] d; int cyc; bit to;
        issue(3'd4, 32'hFFFF_FFEC, 32'd3);
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div got %h to=%b exp fffffffa", d, to); end
        issue(3'd6, 32'hFFFF_FFEC, 32'd3);
        checks++; if ({md_operator_o, md_signed_mode_o} !== 4'b1111) begin
            errors++; $display("FAIL rem_decode got %b exp 1111", {md_operator_o, md_signed_mode_o}); end
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem got %h to=%b exp fffffffe", d, to); end
        issue(3'd5, 32'h1234_5678, 32'd0);
        checks++; if (md_equal_to_zero_o !== 1'b1 || md_signed_mode_o !== 2'b00) begin
            errors++; $display("FAIL divu0_flags got ez=%b sm=%b exp 1/00", md_equal_to_zero_o, md_signed_mode_o); end
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0 got %h to=%b exp ffffffff", d, to); end
        checks++; if (cyc > 8) begin errors++; $display("FAIL divu0_fast got %0d cycles exp <=8", cyc); end
    endtask

    task automatic test_mulh();
        logic [31:0] d; int cyc; bit to;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (md_signed_mode_o !== 2'b00 || md_operator_o !== 2'd1) begin
            errors++; $display("FAIL mulhu_decode got sm=%b op=%0d exp 00/1", md_signed_mode_o, md_operator_o); end
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h to=%b exp fffffffe", d, to); end
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        checks++; if (md_signed_mode_o !== 2'b01) begin errors++; $display("FAIL mulhsu_mode got %b exp 01", md_signed_mode_o); end
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h to=%b exp ffffffff", d, to); end
    endtask

    task automatic test_flush_drain();
        logic [31:0] d; int cyc; bit to; int drops = 0; int vld = 0; bit seen = 1'b0;
        issue(3'd4, 32'hFFFF_FFEC, 32'd3);
        repeat (4) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if ({busy_o, md_div_en_o, rsp_valid_o, req_ready_o} !== 4'b1100) begin
            errors++; $display("FAIL drain_entry got %b exp 1100", {busy_o, md_div_en_o, rsp_valid_o, req_ready_o}); end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || md_div_en_o !== 1'b1) begin
            errors++; $display("FAIL drain_flush_ignored got busy=%b en=%b exp 1/1", busy_o, md_div_en_o); end
        for (int i = 0; i < 200; i++) begin
            if (!md_div_en_o) drops++;
            if (rsp_valid_o) vld++;
            if (md_ready_i) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen || drops != 0 || vld != 0) begin
            errors++; $display("FAIL drain_hold got ready=%b drops=%0d vld=%0d exp 1/0/0", seen, drops, vld); end
        @(negedge clk);
        checks++; if ({busy_o, md_div_en_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
            errors++; $display("FAIL drain_exit got %b exp 0001", {busy_o, md_div_en_o, rsp_valid_o, req_ready_o}); end
        issue(3'd0, 32'd3, 32'd4);
        wait_rsp(d, cyc, to); take_rsp();
        checks++; if (to || d !== 32'd12) begin errors++; $display("FAIL post_flush_mul got %h to=%b exp c", d, to); end
    endtask

    task automatic test_back_to_back_arb();
        logic [31:0] d; int cyc; bit to; int bad = 0;
        alu_req_i = 1'b1;
        @(negedge clk);
        checks++; if (alu_gnt_o !== 1'b1 || adder_sel_o !== 1'b0) begin
            errors++; $display("FAIL arb_idle got gnt=%b sel=%b exp 1/0", alu_gnt_o, adder_sel_o); end
        issue(3'd0, 32'd5, 32'd6);
        for (int i = 0; i < 200 && !rsp_valid_o; i++) begin
            if (alu_gnt_o !== 1'b0 || adder_sel_o !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL arb_run got %0d bad cycles exp 0", bad); end
        wait_rsp(d, cyc, to);
        checks++; if (to || d !== 32'd30) begin errors++; $display("FAIL bp_data got %h to=%b exp 1e", d, to); end
        bad = 0;
        req_valid_i = 1'b1; req_op_i = 3'd0; req_a_i = 32'd1; req_b_i = 32'd1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd30 || req_ready_o !== 1'b0 || alu_gnt_o !== 1'b1) bad++;
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
        take_rsp();
        checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || alu_gnt_o !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b busy=%b gnt=%b exp 0/0/1", rsp_valid_o, busy_o, alu_gnt_o); end
        alu_req_i = 1'b0;
    endtask

    task automatic test_rsp_flush();
        logic [31:0] d; int cyc; bit to;
        issue(3'd0, 32'd2, 32'd2);
        wait_rsp(d, cyc, to);
        flush_i = 1'b1; rsp_ready_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; rsp_ready_i = 1'b0;
        checks++; if (to || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rsp_flush got to=%b v=%b busy=%b exp 0/0/0", to, rsp_valid_o, busy_o); end
    endtask

    task automatic test_timeout();
        dp_hang = 1'b1;
        issue(3'd4, 32'd9, 32'd2);
        repeat (63) @(negedge clk);
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b1 || md_div_en_o !== 1'b1) begin
            errors++; $display("FAIL timeout_early got err=%b busy=%b en=%b exp 0/1/1", err_o, busy_o, md_div_en_o); end
        @(negedge clk);
        checks++; if ({err_o, busy_o, md_div_en_o, md_mult_en_o, req_ready_o} !== 5'b10001) begin
            errors++; $display("FAIL timeout_hit got %b exp 10001", {err_o, busy_o, md_div_en_o, md_mult_en_o, req_ready_o}); end
        repeat (3) @(negedge clk);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", err_o); end
        issue(3'd0, 32'd1, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({err_o, busy_o, md_mult_en_o, adder_sel_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_op got %b exp 0000", {err_o, busy_o, md_mult_en_o, adder_sel_o}); end
        @(negedge clk);
        rst = 1'b0;
        dp_hang = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_rem();
        test_mulh();
        test_flush_drain();
        test_back_to_back_arb();
        test_rsp_flush();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
